// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One radix-2 step per cycle in CALC; FIX applies signs and commits the result.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int OPW   = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b;
  logic               is_div, neg_q, neg_r, divz;

  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     madd, rsh, rdiff;
  logic [2*WIDTH-1:0] step_acc, neg_acc;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign sa    = !op[0] && portA[WIDTH-1];
  assign sb    = !op[0] && portB[WIDTH-1];
  assign abs_a = sa ? -portA : portA;
  assign abs_b = sb ? -portB : portB;

  // acc holds {partial_hi, multiplier} for multiply, {remainder, dividend/quotient} for divide
  always_comb begin
    madd  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
    rsh   = acc[2*WIDTH-1:WIDTH-1];
    rdiff = rsh - {1'b0, b};
    if (is_div)
      step_acc = rdiff[WIDTH] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                              : {rdiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      step_acc = {madd, acc[WIDTH-1:1]};
  end

  always_comb begin
    neg_acc = -acc;
    fix_hi  = acc[2*WIDTH-1:WIDTH];
    fix_lo  = acc[WIDTH-1:0];
    if (divz) begin
      fix_hi = acc[2*WIDTH-1:WIDTH];
      fix_lo = acc[WIDTH-1:0];
    end else if (is_div) begin
      if (neg_q) fix_lo = -acc[WIDTH-1:0];
      if (neg_r) fix_hi = -acc[2*WIDTH-1:WIDTH];
    end else if (neg_q) begin
      fix_hi = neg_acc[2*WIDTH-1:WIDTH];
      fix_lo = neg_acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      b      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      divz   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            b      <= abs_b;
            dz     <= 1'b0;
            busy   <= 1'b1;
            cnt    <= '0;
            // divide by zero skips CALC; FIX just copies acc out
            if (op[1] && portB == '0) begin
              divz  <= 1'b1;
              acc   <= {portA, {WIDTH{1'b1}}};
              state <= FIX;
            end else begin
              divz  <= 1'b0;
              acc   <= {{WIDTH{1'b0}}, abs_a};
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            acc <= step_acc;
            if (cnt == CW'(WIDTH-1)) begin
              cnt   <= '0;
              state <= FIX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
            dz   <= divz;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit against a 64-bit arithmetic model.
module tb_muldiv_unit;
  logic        CLK = 1'b0;
  logic        nRST, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] portA, portB, wdata, hi, lo;
  logic        busy, done, dz;
  int          errors = 0;
  int          checks = 0;

  muldiv_unit #(.WIDTH(32), .OPW(2)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .portA(portA), .portB(portB),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz)
  );

  always #5 CLK = ~CLK;

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint     sp, sq, sr;
    logic [63:0] up;
    ez = 1'b0;
    case (o)
      2'b00: begin sp = longint'($signed(a)) * longint'($signed(b)); up = 64'(sp); eh = up[63:32]; el = up[31:0]; end
      2'b01: begin up = 64'(a) * 64'(b); eh = up[63:32]; el = up[31:0]; end
      default: begin
        if (b == 0) begin
          eh = a; el = 32'hFFFF_FFFF; ez = 1'b1;
        end else if (o == 2'b10) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          el = 32'(sq); eh = 32'(sr);
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int bcnt);
    @(negedge CLK);
    start = 1'b1; op = o; portA = a; portB = b;
    @(posedge CLK); #1;
    start = 1'b0;
    cyc = 1;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 200) begin
      @(posedge CLK); #1;
      cyc++;
      if (busy) bcnt++;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL op_timeout op=%0d got no done, required done within 200", o); end
  endtask

  task automatic check_rand(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string nm);
    logic [31:0] eh, el;
    logic ez;
    int cyc, bc;
    model(o, a, b, eh, el, ez);
    run_op(o, a, b, cyc, bc);
    checks++; if (hi !== eh) begin errors++; $display("FAIL %s_hi a=%h b=%h got %h need %h", nm, a, b, hi, eh); end
    checks++; if (lo !== el) begin errors++; $display("FAIL %s_lo a=%h b=%h got %h need %h", nm, a, b, lo, el); end
    checks++; if (dz !== ez) begin errors++; $display("FAIL %s_dz a=%h b=%h got %b need %b", nm, a, b, dz, ez); end
  endtask

  task automatic test_reset();
    nRST = 1'b0; start = 0; flush = 0; hi_we = 0; lo_we = 0; op = 0; portA = 0; portB = 0; wdata = 0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h need 0", {hi, lo}); end
    checks++; if ({busy, done, dz} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b need 000", {busy, done, dz}); end
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_mult();
    int cyc, bc;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, cyc, bc);
    checks++; if (cyc != 34) begin errors++; $display("FAIL mult_latency got %0d need 34", cyc); end
    checks++; if (bc != 33) begin errors++; $display("FAIL mult_busy_cycles got %0d need 33", bc); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h need ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h need fffffff1", lo); end
    @(posedge CLK); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b need 0", done); end
    for (int i = 0; i < 6; i++) check_rand(2'b00, $urandom, $urandom, "mult_rand");
  endtask

  task automatic test_multu_b2b();
    int cyc, bc;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bc);
    checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max got %h need fffffffe00000001", {hi, lo}); end
    // next start lands in the done cycle
    run_op(2'b01, 32'd1234567, 32'd7654321, cyc, bc);
    checks++; if (cyc != 34) begin errors++; $display("FAIL b2b_latency got %0d need 34", cyc); end
    checks++; if ({hi, lo} !== 64'(64'd1234567 * 64'd7654321)) begin errors++; $display("FAIL b2b_result got %h", {hi, lo}); end
    for (int i = 0; i < 6; i++) check_rand(2'b01, $urandom, $urandom, "multu_rand");
  endtask

  task automatic test_div();
    int cyc, bc;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc, bc);
    checks++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_neg7_2 got %h", {hi, lo}); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bc);
    checks++; if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_minneg got %h need 0000000080000000", {hi, lo}); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_minneg_dz got %b need 0", dz); end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 3 == 0) ? ($urandom & 32'hFF) - 32'd128 : $urandom;
      if (i == 5) b = 0;
      check_rand(2'b10, a, b, "div_rand");
    end
  endtask

  task automatic test_divu();
    int cyc, bc;
    run_op(2'b11, 32'd7, 32'd0, cyc, bc);
    checks++; if (cyc != 2) begin errors++; $display("FAIL divz_latency got %0d need 2", cyc); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL divz_flag got %b need 1", dz); end
    checks++; if ({hi, lo} !== {32'd7, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divz_result got %h", {hi, lo}); end
    run_op(2'b11, 32'd9, 32'd4, cyc, bc);
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL divu_dz_clear got %b need 0", dz); end
    checks++; if ({hi, lo} !== {32'd1, 32'd2}) begin errors++; $display("FAIL divu_9_4 got %h", {hi, lo}); end
    for (int i = 0; i < 6; i++) check_rand(2'b11, $urandom, $urandom >> (i * 5), "divu_rand");
  endtask

  task automatic test_flush_hilo();
    logic [31:0] hi_old;
    int seen;
    @(negedge CLK); lo_we = 1'b1; wdata = 32'h1234;
    @(negedge CLK); lo_we = 1'b0;
    hi_old = hi;
    checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL mtlo got %h need 00001234", lo); end
    start = 1'b1; op = 2'b00; portA = 32'd3; portB = 32'd4;
    @(posedge CLK); #1; start = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK); hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge CLK); hi_we = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); flush = 1'b1;
    @(posedge CLK); #1; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b need 0", busy); end
    seen = 0;
    repeat (40) begin @(posedge CLK); #1; if (done) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_done got %0d pulses need 0", seen); end
    checks++; if (lo !== 32'h1234) begin errors++; $display("FAIL flush_lo got %h need 00001234", lo); end
    checks++; if (hi !== hi_old) begin errors++; $display("FAIL flush_hi got %h need %h", hi, hi_old); end
    // flush in IDLE blocks a start
    @(negedge CLK); start = 1'b1; flush = 1'b1; op = 2'b01; portA = 5; portB = 5;
    @(posedge CLK); #1; start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_flush_start got busy=%b need 0", busy); end
    // write and start together: write lands, result overwrites later
    @(negedge CLK); start = 1'b1; hi_we = 1'b1; wdata = 32'hCAFE; op = 2'b01; portA = 6; portB = 7;
    @(posedge CLK); #1; start = 1'b0; hi_we = 1'b0;
    checks++; if (hi !== 32'hCAFE) begin errors++; $display("FAIL mthi_with_start got %h need 0000cafe", hi); end
    seen = 0;
    while (!done && seen < 200) begin @(posedge CLK); #1; seen++; end
    checks++; if ({hi, lo} !== {32'd0, 32'd42}) begin errors++; $display("FAIL write_then_op got %h need 42", {hi, lo}); end
  endtask

  task automatic test_reset_mid();
    int cyc, bc;
    @(negedge CLK); start = 1'b1; op = 2'b01; portA = 32'hFFFF; portB = 32'hFFFF;
    @(posedge CLK); #1; start = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK); nRST = 1'b0; #1;
    checks++; if ({busy, done, dz} !== 3'b000) begin errors++; $display("FAIL midreset_flags got %b need 000", {busy, done, dz}); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL midreset_hilo got %h need 0", {hi, lo}); end
    @(negedge CLK); nRST = 1'b1;
    run_op(2'b01, 32'd2, 32'd3, cyc, bc);
    checks++; if ({hi, lo} !== {32'd0, 32'd6}) begin errors++; $display("FAIL post_reset_multu got %h need 6", {hi, lo}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_b2b();
    test_div();
    test_divu();
    test_flush_hilo();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
